two_input_arbiter: RTL and testbench
====================================

// Module: two_input_arbiter
// PURPOSE
//   Two-requester round-robin arbiter node for building arbitration trees.
//   ORs local requests into arb_req toward the next-level arbiter.
//   Forwards that arbiter's arb_grant to exactly one local requester, chosen by a
//   rotating priority pointer, so two persistent requesters alternate fairly.
// PARAMETERS
//   RESET_PRIO  1'b0  requester that has priority after reset (0 -> req0, 1 -> req1)
// PORTS
//   clk        in   1  single clock; all state updates on rising edge
//   rst        in   1  synchronous reset, active-high
//   req0       in   1  request from requester 0
//   req1       in   1  request from requester 1
//   grant0     out  1  grant to requester 0
//   grant1     out  1  grant to requester 1
//   arb_req    out  1  request to next-level arbiter
//   arb_grant  in   1  grant from next-level arbiter (tie to 1 at tree root)
// BEHAVIOUR
//   - Interface: one clock; reset is synchronous and active-high.
//   - State: 1-bit priority pointer prio (0 = req0 favoured, 1 = req1 favoured).
//   - Reset: prio <= RESET_PRIO.
//     While rst=1, grant0 = grant1 = arb_req = 0, forced combinationally.
//   - arb_req = (req0 | req1) & ~rst. Purely combinational, zero latency.
//   - Selection (combinational):
//       only req0 -> sel 0; only req1 -> sel 1; both -> sel prio; none -> no sel.
//   - grant0 = arb_grant & sel0 & ~rst.
//     grant1 = arb_grant & sel1 & ~rst.
//     Grants are one-hot or zero, never both.
//   - Pointer update at posedge, only when a grant is issued (grant0|grant1):
//       grant0 -> prio <= 1; grant1 -> prio <= 0.
//     No grant (no request, or arb_grant=0) -> prio holds.
//   - Result: with both requests held and arb_grant=1, grants alternate every cycle:
//     g0, g1, g0, ... for RESET_PRIO=0.
//   - A lone requester is granted every cycle that arb_grant=1; the pointer
//     still toggles to favour the other input next.
//   - Request withdrawn mid-stream: the next cycle uses the current prio; no
//     stale grant is issued.
//   - arb_grant with no request: ignored (no grant, prio unchanged).
//   - Reset asserted mid-operation: grants drop in the same cycle; prio is
//     restored on the next edge.
// CONFIGURATION
//   TWO_INPUT_ARB_ASSERT_EN defined: simulation-only SVA is compiled in:
//     - never grant0 & grant1;
//     - grantN implies reqN & arb_grant;
//     - arb_req == req0|req1 outside reset;
//     - both requesting with arb_grant=1 for 2 consecutive cycles implies each
//       gets one grant.
//   TWO_INPUT_ARB_ASSERT_EN undefined: no assertions; logic is identical.
// STRUCTURE
//   - Shared package arb_pkg: typedef enum logic {PRIO_REQ0, PRIO_REQ1} arb_prio_t;
//     localparam arb_prio_t ARB_PRIO_DEFAULT = PRIO_REQ0.
//   - No sub-modules. Flat: one always_ff (prio), one always_comb (select/grant).
//   - Larger trees instantiate this block recursively, with arb_req/arb_grant
//     chained upward.
// TESTING
//   1 rst=1 two cycles, req0=req1=1, arb_grant=1
//     -> grant0=grant1=0, arb_req=0 during reset.
//   2 release rst, req0=req1=1, arb_grant=1 for 8 cycles
//     -> grants 10,01,10,01,10,01,10,01 (grant0 grant1).
//   3 req0=1, req1=0, arb_grant=1 for 4 cycles
//     -> grant0=1 every cycle; then raise req1 -> grant1 wins next cycle.
//   4 req0=req1=1, arb_grant=0 for 3 cycles
//     -> arb_req=1, no grants, prio frozen; arb_grant=1 resumes the same winner.
//   5 req0=req1=0, arb_grant=1 -> arb_req=0, no grants, prio unchanged.
//   6 mid-stream rst pulse after a grant1
//     -> grants 0 during reset; next grant (both requesting) goes to req0.

Source files
------------

// File: rtl/arb_pkg.sv
// ---------------------------------------------------------------------------
// arb_pkg
//   Shared types and constants for the arbitration-tree building blocks.
//
//   arb_prio_t        : which requester the round-robin pointer favours.
//   ARB_PRIO_DEFAULT  : pointer value used after reset unless a node
//                       overrides it.
//   arb_other()       : helper that flips the pointer to favour the other
//                       requester after one side has been served.
// ---------------------------------------------------------------------------
package arb_pkg;

    typedef enum logic {
        PRIO_REQ0 = 1'b0,
        PRIO_REQ1 = 1'b1
    } arb_prio_t;

    localparam arb_prio_t ARB_PRIO_DEFAULT = PRIO_REQ0;

    // Once a requester has been served, priority passes to the other side.
    function automatic arb_prio_t arb_other(input arb_prio_t served);
        return (served == PRIO_REQ0) ? PRIO_REQ1 : PRIO_REQ0;
    endfunction

endpackage

// File: rtl/two_input_arbiter.sv
// ---------------------------------------------------------------------------
// two_input_arbiter
//   Two-requester round-robin arbiter node for building arbitration trees.
//   Local requests are ORed into arb_req toward the next-level arbiter; the
//   grant coming back (arb_grant) is steered to exactly one local requester,
//   chosen by a 1-bit rotating priority pointer, so two persistent requesters
//   alternate fairly. At the tree root, tie arb_grant to 1.
//
// Parameters
//   RESET_PRIO  pointer value after reset (PRIO_REQ0 -> req0 favoured)
//
// Ports
//   clk        in   single clock, rising-edge state updates
//   rst        in   synchronous reset, active-high; also forces all
//                   outputs low combinationally while asserted
//   req0       in   request from requester 0
//   req1       in   request from requester 1
//   grant0     out  grant to requester 0
//   grant1     out  grant to requester 1
//   arb_req    out  request toward the next-level arbiter
//   arb_grant  in   grant from the next-level arbiter
//
// Configuration
//   TWO_INPUT_ARB_ASSERT_EN  when defined, simulation-only SVA checks are
//                            compiled in; the logic is identical either way.
// ---------------------------------------------------------------------------
module two_input_arbiter
    import arb_pkg::*;
#(
    parameter arb_prio_t RESET_PRIO = ARB_PRIO_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic req0,
    input  logic req1,
    output logic grant0,
    output logic grant1,
    output logic arb_req,
    input  logic arb_grant
);

    arb_prio_t prio;
    arb_prio_t prio_next;
    logic      sel0;
    logic      sel1;

    // Selection, grant steering and next pointer value. With both inputs
    // requesting the pointer breaks the tie; a lone requester is always
    // selected. The pointer only moves when a grant is actually issued, so a
    // stalled upstream (arb_grant=0) or an idle node leaves fairness intact.
    always_comb begin
        sel0      = 1'b0;
        sel1      = 1'b0;
        grant0    = 1'b0;
        grant1    = 1'b0;
        arb_req   = 1'b0;
        prio_next = prio;

        if (req0 && req1) begin
            sel0 = (prio == PRIO_REQ0);
            sel1 = (prio == PRIO_REQ1);
        end else begin
            sel0 = req0;
            sel1 = req1;
        end

        if (!rst) begin
            arb_req = req0 | req1;
            grant0  = arb_grant & sel0;
            grant1  = arb_grant & sel1;
        end

        if (grant0) begin
            prio_next = arb_other(PRIO_REQ0);
        end else if (grant1) begin
            prio_next = arb_other(PRIO_REQ1);
        end
    end

    // Priority pointer register; reset is sampled on the clock edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            prio <= RESET_PRIO;
        end else begin
            prio <= prio_next;
        end
    end

`ifdef TWO_INPUT_ARB_ASSERT_EN
    // Grants are one-hot or zero.
    a_onehot: assert property (@(posedge clk) !(grant0 && grant1));

    // A grant is only ever issued to a live requester while upstream grants.
    a_grant0_valid: assert property (@(posedge clk) grant0 |-> (req0 && arb_grant));
    a_grant1_valid: assert property (@(posedge clk) grant1 |-> (req1 && arb_grant));

    // Outside reset the upstream request mirrors the local requests.
    a_arb_req: assert property (@(posedge clk) disable iff (rst)
        arb_req == (req0 | req1));

    // Two back-to-back contended, granted cycles serve each side once.
    a_fair: assert property (@(posedge clk) disable iff (rst)
        (req0 && req1 && arb_grant) ##1 (req0 && req1 && arb_grant)
        |-> ((grant0 != $past(grant0)) && (grant0 ^ grant1)));
`endif

endmodule

// File: tb/tb_two_input_arbiter.sv
// ---------------------------------------------------------------------------
// tb_two_input_arbiter
//   Scoreboard bench for two_input_arbiter. Each applied vector pushes the
//   expected {grant0, grant1, arb_req} computed from a reference pointer
//   model; the entry is popped and compared once the combinational outputs
//   have settled, well away from the rising edge.
// ---------------------------------------------------------------------------
module tb_two_input_arbiter;
    import arb_pkg::*;

    logic clk;
    logic rst;
    logic req0;
    logic req1;
    logic arb_grant;
    logic grant0;
    logic grant1;
    logic arb_req;

    int vectors;
    int miscompares;

    typedef struct packed {
        logic g0;
        logic g1;
        logic ar;
    } exp_t;

    exp_t exp_q[$];
    logic model_prio;

    two_input_arbiter #(.RESET_PRIO(PRIO_REQ0)) dut (
        .clk       (clk),
        .rst       (rst),
        .req0      (req0),
        .req1      (req1),
        .grant0    (grant0),
        .grant1    (grant1),
        .arb_req   (arb_req),
        .arb_grant (arb_grant)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [2:0] got, input logic [2:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("[TB] FAIL %s got g0g1ar=%b expected %b", tag, got, want);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, push the expected
    // outputs from the reference model, compare after settling, then
    // advance the model across the rising edge.
    task automatic applyStimulus(input string tag, input logic r, input logic q0,
                                 input logic q1, input logic ag);
        exp_t e;
        exp_t popped;
        logic s0;
        logic s1;
        @(negedge clk);
        rst       = r;
        req0      = q0;
        req1      = q1;
        arb_grant = ag;

        if (q0 && q1) begin
            s0 = (model_prio == 1'b0);
            s1 = (model_prio == 1'b1);
        end else begin
            s0 = q0;
            s1 = q1;
        end
        e.g0 = !r && ag && s0;
        e.g1 = !r && ag && s1;
        e.ar = !r && (q0 || q1);
        exp_q.push_back(e);

        #1;
        if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL %s scoreboard empty got 0 entries expected 1", tag);
        end else begin
            popped = exp_q.pop_front();
            checkOutput(tag, {grant0, grant1, arb_req}, popped);
        end

        @(posedge clk);
        if (r)             model_prio = 1'b0;
        else if (e.g0)     model_prio = 1'b1;
        else if (e.g1)     model_prio = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        model_prio  = 1'b0;
        rst         = 1'b1;
        req0        = 1'b0;
        req1        = 1'b0;
        arb_grant   = 1'b0;

        // 1: reset holds every output low even with full demand.
        repeat (2) applyStimulus("reset", 1'b1, 1'b1, 1'b1, 1'b1);

        // 2: both requesting, upstream granting -> strict alternation.
        for (int i = 0; i < 8; i++) applyStimulus("alternate", 1'b0, 1'b1, 1'b1, 1'b1);

        // 3: lone req0 wins every cycle, then req1 arrives and wins at once.
        for (int i = 0; i < 4; i++) applyStimulus("lone_req0", 1'b0, 1'b1, 1'b0, 1'b1);
        applyStimulus("req1_joins", 1'b0, 1'b1, 1'b1, 1'b1);

        // 4: upstream stall freezes the pointer; same winner on resume.
        for (int i = 0; i < 3; i++) applyStimulus("stall", 1'b0, 1'b1, 1'b1, 1'b0);
        applyStimulus("resume", 1'b0, 1'b1, 1'b1, 1'b1);

        // 5: upstream grant with no requests is ignored.
        applyStimulus("idle_grant", 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus("after_idle", 1'b0, 1'b1, 1'b1, 1'b1);

        // 6: reset pulses mid-stream, after a grant1 and after a grant0.
        applyStimulus("pre_rst_g0", 1'b0, 1'b1, 1'b1, 1'b1);
        applyStimulus("pre_rst_g1", 1'b0, 1'b1, 1'b1, 1'b1);
        applyStimulus("mid_rst_a", 1'b1, 1'b1, 1'b1, 1'b1);
        applyStimulus("post_rst_a", 1'b0, 1'b1, 1'b1, 1'b1);
        applyStimulus("mid_rst_b", 1'b1, 1'b1, 1'b1, 1'b1);
        applyStimulus("post_rst_b", 1'b0, 1'b1, 1'b1, 1'b1);

        // Withdrawn request: req1 alone after req0 was served must still win.
        applyStimulus("withdraw", 1'b0, 1'b0, 1'b1, 1'b1);
        applyStimulus("lone_req1", 1'b0, 1'b0, 1'b1, 1'b1);

        // Random mix, with occasional reset.
        for (int i = 0; i < 200; i++) begin
            applyStimulus("random", ($urandom_range(0, 19) == 0), $urandom_range(0, 1),
                          $urandom_range(0, 1), ($urandom_range(0, 3) != 0));
        end

        if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL drain leftover=%0d expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
